// File: rtl/fir_frame_sequencer.sv
// Frame controller for one fir_rns core: streams a frame of samples in, waits
// for the core to finish (with a timeout), then serves random-access result reads.
module fir_frame_sequencer #(
  parameter int TAPS         = 10,
  parameter int SIGNAL_COUNT = 10,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [1:0]        core_op,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_x,
  input  logic [DATA_W-1:0] core_y,
  input  logic              core_done,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int STAGES = 1;

  if (TAPS < 1 || (2**ADDR_W) <= SIGNAL_COUNT) begin : g_bad_cfg
    $error("fir_frame_sequencer: TAPS must be >= 1 and 2**ADDR_W > SIGNAL_COUNT");
  end

  // State encoding doubles as the core operation code.
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, COMPUTE = 2'b10, READ = 2'b11} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [TW-1:0]     tcnt;
  logic              restart;
  logic [STAGES:0]   vld_pipe, err_pipe;
  logic              start_go, load_hs, last_hs, done_go, tmo_go, rd_go, rd_inr;

  assign start_go = start && (state == IDLE || state == READ);
  assign load_hs  = (state == LOAD) && in_valid;
  assign last_hs  = load_hs && (cnt == ADDR_W'(SIGNAL_COUNT - 1));
  assign done_go  = (state == COMPUTE) && core_done;
  assign tmo_go   = (state == COMPUTE) && !core_done && (tcnt == TW'(TIMEOUT - 1));
  assign rd_go    = (state == READ) && rd_en && !start;
  assign rd_inr   = rd_addr < ADDR_W'(SIGNAL_COUNT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (restart || start) state_nx = LOAD;
      LOAD:    if (last_hs) state_nx = COMPUTE;
      COMPUTE: if (done_go) state_nx = READ;
               else if (tmo_go) state_nx = IDLE;
      READ:    if (start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    core_op  = state;
    in_ready = (state == LOAD);
    busy     = (state == LOAD) || (state == COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      tcnt        <= '0;
      restart     <= 1'b0;
      core_addr   <= '0;
      core_x      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      vld_pipe    <= '0;
      err_pipe    <= '0;
      rd_data     <= '0;
    end else begin
      // A start from READ parks in IDLE for one cycle so the core sees op 00.
      restart    <= (state == READ) && start;
      frame_done <= done_go;
      if (start_go) begin
        cnt         <= '0;
        timeout_err <= 1'b0;
      end
      if (load_hs) begin
        core_x    <= in_data;
        core_addr <= cnt;
        cnt       <= cnt + 1'b1;
      end
      if (last_hs)                tcnt <= '0;
      else if (state == COMPUTE)  tcnt <= tcnt + 1'b1;
      if (tmo_go)                 timeout_err <= 1'b1;
      if (done_go)                core_addr <= '0;
      if (rd_go && rd_inr)        core_addr <= rd_addr;
      // Stage 0 follows the address update, stage 1 captures the converter output.
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_go};
      err_pipe <= {err_pipe[STAGES-1:0], rd_go && !rd_inr};
      rd_data  <= (vld_pipe[STAGES-1] && !err_pipe[STAGES-1]) ? core_y : '0;
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  assign rd_err   = err_pipe[STAGES];
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer; read results are checked by a
// scoreboard monitor that also enforces the two-cycle read latency.
module tb_fir_frame_sequencer;
  localparam int SC = 10, DW = 32, AW = 8, TO = 16;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, rd_en, rd_valid, rd_err;
  logic core_done, busy, frame_done, timeout_err;
  logic [DW-1:0] in_data, rd_data, core_x, core_y, y_base;
  logic [AW-1:0] rd_addr, core_addr;
  logic [1:0]    core_op;
  int checks = 0, errors = 0, cyc = 0, n;

  typedef struct packed {logic [DW-1:0] data; logic err; int due;} rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign core_y = y_base + DW'(core_addr);

  fir_frame_sequencer #(.TAPS(10), .SIGNAL_COUNT(SC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .core_op(core_op), .core_addr(core_addr),
    .core_x(core_x), .core_y(core_y), .core_done(core_done), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual rd_valid=1 data=%0h required no response", rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_err", rd_err, e.err);
        chk("rd_latency", cyc, e.due);
      end
    end
  end

  task automatic rd_req(input logic [AW-1:0] a);
    rsp_t r;
    rd_en = 1'b1; rd_addr = a;
    r.data = (a < SC) ? y_base + DW'(a) : '0;
    r.err  = (a >= SC);
    r.due  = cyc + 2;
    exp_q.push_back(r);
    tick();
  endtask

  task automatic load_frame(input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input int gap, input bit noise);
    for (int i = 0; i < SC; i++) begin
      if (i > 0) for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; start = noise; rd_en = noise; rd_addr = '0;
        tick();
        chk("ld_hold_x", core_x, base + step * DW'(i - 1));
        chk("ld_hold_addr", core_addr, 64'(i - 1));
        chk("ld_gap_op", core_op, 2'b01);
      end
      start = 1'b0; rd_en = 1'b0;
      in_valid = 1'b1; in_data = base + step * DW'(i);
      chk("ld_ready", in_ready, 1'b1);
      tick();
      chk("ld_x", core_x, base + step * DW'(i));
      chk("ld_addr", core_addr, 64'(i));
      chk("ld_op_after", core_op, (i == SC - 1) ? 2'b10 : 2'b01);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, core_op, 2'b00);
    chk({tag, "_addr"}, core_addr, 0);
    chk({tag, "_x"}, core_x, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_rdd"}, rd_data, 0);
    chk({tag, "_rde"}, rd_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0;
    rd_addr = '0; core_done = 1'b0; y_base = 32'd100;
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0; tick();

    // Basic frame
    start = 1'b1; tick(); start = 1'b0;
    chk("start_op", core_op, 2'b01);
    chk("start_ready", in_ready, 1'b1);
    chk("start_busy", busy, 1'b1);
    load_frame(32'd0, 32'd1, 0, 1'b0);
    repeat (4) tick();
    chk("compute_busy", busy, 1'b1);
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("done_op", core_op, 2'b11);
    chk("done_pulse", frame_done, 1'b1);
    chk("done_addr", core_addr, 0);
    tick();
    chk("done_pulse_end", frame_done, 1'b0);
    for (int a = 0; a < SC; a++) rd_req(AW'(a));

    // Out-of-range reads leave the core address alone
    rd_req(8'd10);
    chk("oor_addr_hold", core_addr, 9);
    rd_req(8'd255);
    chk("oor_addr_hold2", core_addr, 9);
    rd_en = 1'b0;
    repeat (3) tick();

    // Re-trigger from READ with a colliding read that must be dropped
    start = 1'b1; rd_en = 1'b1; rd_addr = 8'd3; tick();
    start = 1'b0; rd_en = 1'b0;
    chk("retrig_idle_op", core_op, 2'b00);
    chk("retrig_idle_ready", in_ready, 1'b0);
    tick();
    chk("retrig_load_op", core_op, 2'b01);
    load_frame(32'd50, 32'd3, 2, 1'b1);
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("f2_op", core_op, 2'b11);
    y_base = 32'hFFFF_FF00;
    rd_req(8'd5); rd_req(8'd0); rd_req(8'd9);
    rd_en = 1'b0;
    repeat (3) tick();

    // Timeout, with a start in COMPUTE that must be ignored
    start = 1'b1; tick(); start = 1'b0;
    tick();
    load_frame(32'd1000, 32'd1, 0, 1'b0);
    n = 0;
    while (core_op == 2'b10 && n < 40) begin
      start = (n == 3);
      n++; tick();
    end
    start = 1'b0;
    chk("tmo_cycles", n, TO);
    chk("tmo_op", core_op, 2'b00);
    chk("tmo_flag", timeout_err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    tick();
    chk("tmo_sticky", timeout_err, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_clear", timeout_err, 1'b0);
    chk("tmo_restart_op", core_op, 2'b01);

    // Reset mid-frame after 4 samples
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(7 + i); tick();
    end
    chk("mid_addr", core_addr, 3);
    reset = 1'b1; start = 1'b1; tick();
    chk_reset_vals("midrst");
    tick();
    chk("midrst_start_ign", core_op, 2'b00);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; tick();
    chk("postrst_op", core_op, 2'b00);
    chk("postrst_ready", in_ready, 1'b0);

    // Fresh frame; core_done on the final timeout cycle still wins
    start = 1'b1; tick(); start = 1'b0;
    load_frame(32'd40, 32'd2, 1, 1'b0);
    repeat (TO - 1) tick();
    chk("edge_still_compute", core_op, 2'b10);
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("edge_op", core_op, 2'b11);
    chk("edge_fdone", frame_done, 1'b1);
    chk("edge_tmo", timeout_err, 1'b0);
    y_base = 32'd300;
    rd_req(8'd3); rd_req(8'd9); rd_req(8'd11);
    chk("edge_oor_hold", core_addr, 9);
    rd_en = 1'b0;
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
